conv_stream_ctrl: RTL and testbench
===================================

// Module: conv_stream_ctrl
// PURPOSE
//  Sequencer for the KxK PE-array convolution wrapper. Fetches an image from a word-addressed buffer.
//  Each word is one column of K vertically stacked pixels.
//  Walks the image strip by strip, column by column, and drives the array's enable and pixel bus.
//  Counts the array's done strobes, tags each result with its (strip, col) and signals completion.
// PARAMETERS
//  KERNEL_SIZE    3    K; pixels per word, rows per strip
//  DATA_WIDTH     8    bits per pixel
//  DIM_WIDTH      10   width of img_width / n_strips / coordinate counters
//  ADDR_WIDTH     16   buffer address width
//  STRIP_GAP      3    idle pe_en=0 cycles inserted between strips (>=1)
//  DRAIN_TIMEOUT  64   max cycles waiting in DRAIN for outstanding results
// PORTS
//  clk          in   1                    clock, rising edge
//  rst          in   1                    reset, asynchronous, active-high
//  start        in   1                    1-cycle pulse; launches a frame when idle
//  img_width    in   DIM_WIDTH            columns per strip, sampled on accepted start
//  n_strips     in   DIM_WIDTH            strips per frame, sampled on accepted start
//  mem_rd_en    out  1                    buffer read strobe
//  mem_addr     out  ADDR_WIDTH           buffer word address
//  mem_rd_data  in   DATA_WIDTH*K         word, valid the cycle after mem_rd_en
//  pe_ready     in   1                    array ready
//  pe_en        out  1                    array enable / pixel valid
//  pe_dataIn    out  DATA_WIDTH*K         pixel column to array
//  pe_done      in   1                    array result strobe
//  res_valid    out  1                    registered copy of pe_done
//  res_strip    out  DIM_WIDTH            strip index of result
//  res_col      out  DIM_WIDTH            column index of result
//  busy         out  1                    high from accepted start until done/err
//  done         out  1                    1-cycle pulse, frame complete
//  err          out  1                    sticky; cleared by next accepted start
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, all counters 0; async assert, sync release.
//  FSM: IDLE -> STREAM -> (GAP -> STREAM)* -> DRAIN -> FINISH -> IDLE.
//  IDLE: start && pe_ready accepted; latch dims, clear err/counters, busy=1.
//    Accepted start with img_width==0 or n_strips==0 -> FINISH directly; no reads.
//    start with pe_ready=0 is ignored. start while busy is ignored.
//  STREAM: one read/cycle; mem_rd_en=1, mem_addr=base+col.
//    base is an accumulator: +=img_width per strip, no multiplier; addr wraps mod 2^ADDR_WIDTH.
//  Datapath: read in cycle T -> pe_dataIn registered from mem_rd_data at end of T+1 -> pe_en=1 in T+2.
//    Fixed 2-cycle issue-to-pe_en latency. pe_dataIn holds its last value while pe_en=0.
//  Last column of a strip: if more strips remain -> GAP, else -> DRAIN.
//  GAP: exactly STRIP_GAP cycles with mem_rd_en=0, then STREAM with col=0, strip+1.
//  Result tracking: each pe_done -> res_valid next cycle, stamped with result counters (rs,rc).
//    Counters then advance rc++, wrapping at img_width-1 to 0 with rs++.
//    pe_done in any state other than STREAM/GAP/DRAIN is ignored and sets err.
//  DRAIN: leave when result count == img_width*n_strips -> FINISH.
//    Leave when DRAIN_TIMEOUT cycles elapse -> FINISH with err=1.
//    A pe_done in the same cycle as timeout is counted first.
//  FINISH: done=1 for 1 cycle, busy=0 next cycle, -> IDLE.
//  pe_ready low while busy: abort at next edge.
//    mem_rd_en=0; in-flight pe_en is suppressed; err=1, done=1, busy drops -> IDLE.
//  rst mid-frame: everything returns to reset values immediately; no done pulse.
// TESTING
//  K=3, W=4, S=2, pe_done 3 cyc after each pe_en -> addrs 0..3 then 4..7.
//    Exactly 3 idle cycles between strips; 8 res_valid with (0,0)..(1,3); done once; err=0.
//  W=1, S=1 -> one read at addr 0; pe_en 2 cycles later; done after the single pe_done.
//  W=0, S=5 -> no mem_rd_en; done pulses 2 cycles after start; err=0.
//  W=4, S=1, only 3 pe_done returned -> done with err=1 exactly DRAIN_TIMEOUT cycles into DRAIN.
//  Drop pe_ready at column 2 of strip 0 -> reads stop next cycle, err=1, done=1, busy=0.
//  Assert rst mid-STREAM -> all outputs 0 asynchronously; a new start after release runs a clean frame.

Source files
------------

// File: rtl/conv_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : conv_stream_ctrl
//  Description : Frame sequencer for the KxK PE-array convolution wrapper.
//                Streams image columns from a word-addressed buffer strip by
//                strip, feeds the array, tags returned results with their
//                (strip, col) position and reports completion / errors.
//  Revision    : 1.0  initial release
// ============================================================================
module conv_stream_ctrl #(
    parameter int KERNEL_SIZE   = 3,
    parameter int DATA_WIDTH    = 8,
    parameter int DIM_WIDTH     = 10,
    parameter int ADDR_WIDTH    = 16,
    parameter int STRIP_GAP     = 3,
    parameter int DRAIN_TIMEOUT = 64
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [DIM_WIDTH-1:0]              img_width,
    input  logic [DIM_WIDTH-1:0]              n_strips,
    output logic                              mem_rd_en,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    input  logic [DATA_WIDTH*KERNEL_SIZE-1:0] mem_rd_data,
    input  logic                              pe_ready,
    output logic                              pe_en,
    output logic [DATA_WIDTH*KERNEL_SIZE-1:0] pe_dataIn,
    input  logic                              pe_done,
    output logic                              res_valid,
    output logic [DIM_WIDTH-1:0]              res_strip,
    output logic [DIM_WIDTH-1:0]              res_col,
    output logic                              busy,
    output logic                              done,
    output logic                              err
);

    localparam int c_word_w = DATA_WIDTH * KERNEL_SIZE;
    localparam int c_gap_w  = (STRIP_GAP > 1) ? $clog2(STRIP_GAP) : 1;
    localparam int c_tmo_w  = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;

    localparam logic [c_gap_w-1:0]   c_gap_last = c_gap_w'(STRIP_GAP - 1);
    localparam logic [c_gap_w-1:0]   c_gap_one  = c_gap_w'(1);
    localparam logic [c_tmo_w-1:0]   c_tmo_last = c_tmo_w'(DRAIN_TIMEOUT - 1);
    localparam logic [c_tmo_w-1:0]   c_tmo_one  = c_tmo_w'(1);
    localparam logic [DIM_WIDTH-1:0] c_dim_one  = DIM_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_STREAM = 3'd1,
        S_GAP    = 3'd2,
        S_DRAIN  = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t                 state_q,     state_d;
    logic [DIM_WIDTH-1:0]   width_q,     width_d;
    logic [DIM_WIDTH-1:0]   nstrips_q,   nstrips_d;
    logic [DIM_WIDTH-1:0]   col_q,       col_d;
    logic [DIM_WIDTH-1:0]   strip_q,     strip_d;
    logic [ADDR_WIDTH-1:0]  base_q,      base_d;
    logic [c_gap_w-1:0]     gap_q,       gap_d;
    logic [c_tmo_w-1:0]     drain_q,     drain_d;
    logic                   busy_q,      busy_d;
    logic                   done_q,      done_d;
    logic                   err_q,       err_d;
    logic                   rd_v1_q,     rd_v1_d;
    logic                   pe_en_q,     pe_en_d;
    logic [c_word_w-1:0]    pe_data_q,   pe_data_d;
    logic                   res_valid_q, res_valid_d;
    logic [DIM_WIDTH-1:0]   res_strip_q, res_strip_d;
    logic [DIM_WIDTH-1:0]   res_col_q,   res_col_d;
    logic [DIM_WIDTH-1:0]   rs_q,        rs_d;
    logic [DIM_WIDTH-1:0]   rc_q,        rc_d;

    logic w_accept;
    logic w_abort;
    logic w_res_live;
    logic w_res_take;
    logic w_all_in;

    // A start only launches a frame from a fully quiet controller with the array ready.
    assign w_accept   = (state_q == S_IDLE) && start && pe_ready && !busy_q;
    // Losing the array mid-frame kills the frame at the next edge.
    assign w_abort    = (state_q != S_IDLE) && !pe_ready;
    assign w_res_live = (state_q == S_STREAM) || (state_q == S_GAP) || (state_q == S_DRAIN);
    assign w_res_take = pe_done && w_res_live;
    // Result counters wrap rc into rs, so rs reaching n_strips means every result arrived.
    assign w_all_in   = (rs_d == nstrips_q);

    // Frame FSM: next state, strip/column walk, gap and drain timers, status flags.
    always_comb begin
        state_d   = state_q;
        width_d   = width_q;
        nstrips_d = nstrips_q;
        col_d     = col_q;
        strip_d   = strip_q;
        base_d    = base_q;
        gap_d     = gap_q;
        drain_d   = drain_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;

        case (state_q)
            S_IDLE: begin
                busy_d = w_accept;
                if (w_accept) begin
                    width_d   = img_width;
                    nstrips_d = n_strips;
                    err_d     = 1'b0;
                    col_d     = '0;
                    strip_d   = '0;
                    base_d    = '0;
                    gap_d     = '0;
                    drain_d   = '0;
                    if ((img_width == '0) || (n_strips == '0)) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_STREAM;
                    end
                end
            end
            S_STREAM: begin
                if (col_q == width_q - c_dim_one) begin
                    col_d = '0;
                    if (strip_q == nstrips_q - c_dim_one) begin
                        state_d = S_DRAIN;
                        drain_d = '0;
                    end else begin
                        state_d = S_GAP;
                        gap_d   = '0;
                    end
                end else begin
                    col_d = col_q + c_dim_one;
                end
            end
            S_GAP: begin
                if (gap_q == c_gap_last) begin
                    state_d = S_STREAM;
                    strip_d = strip_q + c_dim_one;
                    // Running base avoids a strip*width multiplier; wraps naturally.
                    base_d  = base_q + ADDR_WIDTH'(width_q);
                end else begin
                    gap_d = gap_q + c_gap_one;
                end
            end
            S_DRAIN: begin
                // A result landing on the timeout cycle is counted before timing out.
                if (w_all_in) begin
                    state_d = S_FINISH;
                end else if (drain_q == c_tmo_last) begin
                    state_d = S_FINISH;
                    err_d   = 1'b1;
                end else begin
                    drain_d = drain_q + c_tmo_one;
                end
            end
            S_FINISH: begin
                // done lands next cycle; busy is released one cycle after that.
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (pe_done && !w_res_live) begin
            err_d = 1'b1;
        end

        if (w_abort) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            err_d   = 1'b1;
        end
    end

    // Two-stage pixel pipe: read issue -> buffer data -> registered pixel bus + enable.
    always_comb begin
        rd_v1_d   = (state_q == S_STREAM) && !w_abort;
        pe_en_d   = rd_v1_q && !w_abort;
        pe_data_d = pe_data_q;
        if (rd_v1_q && !w_abort) begin
            pe_data_d = mem_rd_data;
        end
    end

    // Result tagging: stamp each accepted pe_done with the running (strip, col).
    always_comb begin
        res_valid_d = w_res_take;
        res_strip_d = res_strip_q;
        res_col_d   = res_col_q;
        rs_d        = rs_q;
        rc_d        = rc_q;
        if (w_accept) begin
            rs_d = '0;
            rc_d = '0;
        end else if (w_res_take) begin
            res_strip_d = rs_q;
            res_col_d   = rc_q;
            if (rc_q == width_q - c_dim_one) begin
                rc_d = '0;
                rs_d = rs_q + c_dim_one;
            end else begin
                rc_d = rc_q + c_dim_one;
            end
        end
    end

    // State and datapath registers; asynchronous clear to the idle frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            width_q     <= '0;
            nstrips_q   <= '0;
            col_q       <= '0;
            strip_q     <= '0;
            base_q      <= '0;
            gap_q       <= '0;
            drain_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rd_v1_q     <= 1'b0;
            pe_en_q     <= 1'b0;
            pe_data_q   <= '0;
            res_valid_q <= 1'b0;
            res_strip_q <= '0;
            res_col_q   <= '0;
            rs_q        <= '0;
            rc_q        <= '0;
        end else begin
            state_q     <= state_d;
            width_q     <= width_d;
            nstrips_q   <= nstrips_d;
            col_q       <= col_d;
            strip_q     <= strip_d;
            base_q      <= base_d;
            gap_q       <= gap_d;
            drain_q     <= drain_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rd_v1_q     <= rd_v1_d;
            pe_en_q     <= pe_en_d;
            pe_data_q   <= pe_data_d;
            res_valid_q <= res_valid_d;
            res_strip_q <= res_strip_d;
            res_col_q   <= res_col_d;
            rs_q        <= rs_d;
            rc_q        <= rc_d;
        end
    end

    // Reads are issued straight from the walk counters so the latency stays fixed.
    assign mem_rd_en = (state_q == S_STREAM);
    assign mem_addr  = mem_rd_en ? (base_q + ADDR_WIDTH'(col_q)) : '0;
    assign pe_en     = pe_en_q;
    assign pe_dataIn = pe_data_q;
    assign res_valid = res_valid_q;
    assign res_strip = res_strip_q;
    assign res_col   = res_col_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_stream_ctrl
//  Description : Scoreboard bench for conv_stream_ctrl with a buffer model and
//                a PE-array model returning pe_done 3 cycles after pe_en.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_conv_stream_ctrl;

    localparam int K    = 3;
    localparam int DW   = 8;
    localparam int DIMW = 10;
    localparam int AW   = 16;
    localparam int GAP  = 3;
    localparam int TMO  = 64;
    localparam int WW   = K * DW;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            pe_ready = 1'b1;
    logic            pe_done = 1'b0;
    logic [DIMW-1:0] img_width = '0;
    logic [DIMW-1:0] n_strips = '0;
    logic            mem_rd_en;
    logic [AW-1:0]   mem_addr;
    logic [WW-1:0]   mem_rd_data;
    logic            pe_en;
    logic [WW-1:0]   pe_dataIn;
    logic            res_valid;
    logic [DIMW-1:0] res_strip;
    logic [DIMW-1:0] res_col;
    logic            busy;
    logic            done;
    logic            err;

    conv_stream_ctrl #(
        .KERNEL_SIZE(K), .DATA_WIDTH(DW), .DIM_WIDTH(DIMW),
        .ADDR_WIDTH(AW), .STRIP_GAP(GAP), .DRAIN_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .img_width(img_width), .n_strips(n_strips),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .pe_ready(pe_ready), .pe_en(pe_en), .pe_dataIn(pe_dataIn),
        .pe_done(pe_done), .res_valid(res_valid), .res_strip(res_strip),
        .res_col(res_col), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_reads  = 0;
    int done_count = 0;
    int done_cycle = 0;
    int start_cyc  = 0;
    int done_budget = 0;
    int rd_cyc [0:63];
    logic done_prev = 1'b0;

    logic [AW-1:0]       exp_rd  [$];
    logic [WW-1:0]       exp_pe  [$];
    logic [2*DIMW-1:0]   exp_res [$];
    logic                exp_done[$];
    int                  rd_time_q[$];

    function automatic logic [WW-1:0] memword(input int a);
        logic [7:0] b;
        b = 8'(a);
        return {b ^ 8'hA5, b + 8'h40, b + 8'h01};
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic flag_fail(input string name, input longint act);
        n_checks++;
        $display("FAIL %s: got %0d with no expectation queued (cycle %0d)", name, act, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Buffer model: one-cycle read latency.
    logic [WW-1:0] rd_word = '0;
    always @(posedge clk) if (mem_rd_en) rd_word <= memword(int'(mem_addr));
    assign mem_rd_data = rd_word;

    // PE-array model: pe_done 3 cycles after pe_en, for a limited number of results.
    logic [2:0] pd_pipe = '0;
    always @(negedge clk) begin
        pe_done = pd_pipe[2];
        pd_pipe = {pd_pipe[1:0], 1'b0};
        if (pe_en && done_budget > 0) begin
            pd_pipe[0] = 1'b1;
            done_budget--;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents something.
    always @(negedge clk) begin
        if (!rst) begin
            if (done_prev) chk("busy_after_done", busy, 0);
            done_prev = done;
            if (mem_rd_en) begin
                n_reads++;
                if (mem_addr < 64) rd_cyc[int'(mem_addr)] = cyc;
                rd_time_q.push_back(cyc);
                if (exp_rd.size() == 0) flag_fail("rd_unexpected", mem_addr);
                else chk("rd_addr", mem_addr, exp_rd.pop_front());
            end
            if (pe_en) begin
                if (exp_pe.size() == 0) flag_fail("pe_unexpected", pe_dataIn);
                else chk("pe_data", pe_dataIn, exp_pe.pop_front());
                if (rd_time_q.size() != 0) chk("pe_latency", cyc - rd_time_q.pop_front(), 2);
            end
            if (res_valid) begin
                if (exp_res.size() == 0) flag_fail("res_unexpected", {res_strip, res_col});
                else chk("res_tag", {res_strip, res_col}, exp_res.pop_front());
            end
            if (done) begin
                done_count++;
                done_cycle = cyc;
                if (exp_done.size() == 0) flag_fail("done_unexpected", err);
                else chk("done_err", err, exp_done.pop_front());
            end
        end else begin
            done_prev = 1'b0;
        end
    end

    task automatic pulse_start(input int w, input int s);
        @(negedge clk);
        img_width = DIMW'(w);
        n_strips  = DIMW'(s);
        start     = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic expect_frame(input int w, input int s, input int nres);
        for (int a = 0; a < w * s; a++) begin
            exp_rd.push_back(AW'(a));
            exp_pe.push_back(memword(a));
        end
        for (int r = 0; r < nres; r++) exp_res.push_back({DIMW'(r / w), DIMW'(r % w)});
    endtask

    task automatic wait_done(input int base, input int limit);
        int n = 0;
        while (done_count == base && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("frame_done_seen", done_count - base, 1);
    endtask

    task automatic wait_addr2();
        int n = 0;
        while (!(mem_rd_en && mem_addr == 2) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("reached_col2", (n < 50), 1);
    endtask

    initial begin
        int base;
        int rb;
        repeat (3) @(negedge clk);
        chk("rst_mem_rd_en", mem_rd_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_pe_en", pe_en, 0);
        chk("rst_res_valid", res_valid, 0);
        rst = 1'b0;

        // start with the array not ready is ignored
        pe_ready = 1'b0;
        rb = n_reads;
        pulse_start(4, 2);
        repeat (4) @(negedge clk);
        chk("notready_busy", busy, 0);
        chk("notready_reads", n_reads - rb, 0);
        pe_ready = 1'b1;

        // W=4 S=2 full frame; a second start while busy must be ignored
        done_budget = 1000;
        expect_frame(4, 2, 8);
        exp_done.push_back(1'b0);
        base = done_count;
        pulse_start(4, 2);
        repeat (2) @(negedge clk);
        pulse_start(1, 1);
        wait_done(base, 200);
        chk("strip_gap_cycles", rd_cyc[4] - rd_cyc[3], GAP + 1);
        repeat (4) @(negedge clk);
        chk("frame1_done_once", done_count - base, 1);
        chk("frame1_err", err, 0);

        // W=1 S=1 single read; pixel bus then holds its last value
        expect_frame(1, 1, 1);
        exp_done.push_back(1'b0);
        base = done_count;
        pulse_start(1, 1);
        wait_done(base, 100);
        repeat (2) @(negedge clk);
        chk("pe_data_hold", pe_dataIn, memword(0));

        // W=0 S=5: no reads, done two cycles after start
        exp_done.push_back(1'b0);
        base = done_count;
        rb = n_reads;
        pulse_start(0, 5);
        wait_done(base, 20);
        chk("zero_dim_done_latency", done_cycle - start_cyc, 2);
        chk("zero_dim_reads", n_reads - rb, 0);
        chk("zero_dim_err", err, 0);

        // W=4 S=1 with one result missing: drain timeout.
        // DRAIN spans TMO cycles after the last read, then FINISH, then registered done.
        done_budget = 3;
        expect_frame(4, 1, 3);
        exp_done.push_back(1'b1);
        base = done_count;
        pulse_start(4, 1);
        wait_done(base, 200);
        chk("drain_timeout_cycle", done_cycle - rd_cyc[3], TMO + 2);
        @(negedge clk);
        chk("timeout_err_sticky", err, 1);

        // pe_ready dropped at column 2 of strip 0: abort
        done_budget = 0;
        exp_rd.push_back(AW'(0));
        exp_rd.push_back(AW'(1));
        exp_rd.push_back(AW'(2));
        exp_pe.push_back(memword(0));
        exp_done.push_back(1'b1);
        pulse_start(4, 2);
        chk("start_clears_err", err, 0);
        wait_addr2();
        pe_ready = 1'b0;
        @(negedge clk);
        chk("abort_rd_en", mem_rd_en, 0);
        chk("abort_pe_en", pe_en, 0);
        chk("abort_done", done, 1);
        chk("abort_err", err, 1);
        chk("abort_busy", busy, 0);
        pe_ready = 1'b1;
        repeat (4) @(negedge clk);
        rd_time_q.delete();

        // asynchronous reset mid-STREAM, then a clean frame
        exp_rd.push_back(AW'(0));
        exp_rd.push_back(AW'(1));
        exp_rd.push_back(AW'(2));
        exp_pe.push_back(memword(0));
        pulse_start(4, 2);
        wait_addr2();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_mem_rd_en", mem_rd_en, 0);
        chk("arst_mem_addr", mem_addr, 0);
        chk("arst_pe_en", pe_en, 0);
        chk("arst_pe_dataIn", pe_dataIn, 0);
        chk("arst_busy", busy, 0);
        chk("arst_err", err, 0);
        @(negedge clk);
        rst = 1'b0;
        rd_time_q.delete();
        done_budget = 1000;
        expect_frame(2, 2, 4);
        exp_done.push_back(1'b0);
        base = done_count;
        pulse_start(2, 2);
        wait_done(base, 200);
        @(negedge clk);
        chk("post_rst_err", err, 0);

        repeat (6) @(negedge clk);
        chk("left_rd", exp_rd.size(), 0);
        chk("left_pe", exp_pe.size(), 0);
        chk("left_res", exp_res.size(), 0);
        chk("left_done", exp_done.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
